// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef enum logic {
    RESET_FILL = 1'b0,
    RUN        = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/top_fetch_pc_reg.sv
// Program counter flop with reset / redirect / stall priority and the +4 adder.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
);

  logic [WIDTH-1:0] redirect_pc;

  // Wraps modulo 2^WIDTH.
  assign pc_plus4    = pc + WIDTH'(4);
  assign redirect_pc = target & ~WIDTH'(3);

  // Redirect beats stall so a taken branch is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/top_fetch.sv
// Fetch stage: PC register, F/D pipeline register and reset-fill sequencing.
module top_fetch
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             PCsrc_E,
  input  logic [WIDTH-1:0] PCtarget_E,
  input  logic [WIDTH-1:0] instr_F,
  output logic [WIDTH-1:0] pc_F,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCPlus4_D,
  output logic             valid_D
);

  fetch_state_t     state;
  logic [WIDTH-1:0] pc_plus4_F;
  logic [WIDTH-1:0] fill_pc;
  logic [WIDTH-1:0] fill_pc_plus4;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall_F),
    .redirect (PCsrc_E),
    .target   (PCtarget_E),
    .pc       (pc_F),
    .pc_plus4 (pc_plus4_F)
  );

  // The first fetch after reset is pinned to RESET_PC.
  assign fill_pc       = (state == RESET_FILL) ? RESET_PC : pc_F;
  assign fill_pc_plus4 = (state == RESET_FILL) ? RESET_PC + WIDTH'(4) : pc_plus4_F;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_FILL;
    end else begin
      state <= RUN;
    end
  end

  // Flush wins over stall; a bubble is a canonical NOP with valid cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_D   <= WIDTH'(NOP_INSTR);
      PC_D      <= '0;
      PCPlus4_D <= '0;
      valid_D   <= 1'b0;
    end else if (flush_D) begin
      instr_D   <= WIDTH'(NOP_INSTR);
      PC_D      <= '0;
      PCPlus4_D <= '0;
      valid_D   <= 1'b0;
    end else if (!stall_D) begin
      instr_D   <= instr_F;
      PC_D      <= fill_pc;
      PCPlus4_D <= fill_pc_plus4;
      valid_D   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_top_fetch.sv
// Directed self-checking bench for top_fetch with a combinational instruction memory model.
module tb_top_fetch;

  logic        clk;
  logic        rst;
  logic        stall_F;
  logic        stall_D;
  logic        flush_D;
  logic        PCsrc_E;
  logic [31:0] PCtarget_E;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic        valid_D;

  int checkCount;
  int failCount;

  top_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .PCsrc_E    (PCsrc_E),
    .PCtarget_E (PCtarget_E),
    .instr_F    (instr_F),
    .pc_F       (pc_F),
    .instr_D    (instr_D),
    .PC_D       (PC_D),
    .PCPlus4_D  (PCPlus4_D),
    .valid_D    (valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  assign instr_F = memWord(pc_F);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                               input logic src, input logic [31:0] tgt);
    stall_F    = sF;
    stall_D    = sD;
    flush_D    = fD;
    PCsrc_E    = src;
    PCtarget_E = tgt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0);

    repeat (3) tick();
    checkOutput("rst_pc", pc_F, 32'hBFC0_0000);
    checkOutput("rst_valid", {31'b0, valid_D}, 32'h0);
    checkOutput("rst_instr", instr_D, 32'h0000_0013);
    checkOutput("rst_pcd", PC_D, 32'h0);

    rst = 1'b1;
    tick();
    checkOutput("fill_instr", instr_D, 32'hAC97_9BDF);
    checkOutput("fill_pcd", PC_D, 32'hBFC0_0000);
    checkOutput("fill_pc4", PCPlus4_D, 32'hBFC0_0004);
    checkOutput("fill_valid", {31'b0, valid_D}, 32'h1);
    checkOutput("fill_pc", pc_F, 32'hBFC0_0004);

    tick();
    checkOutput("seq_pc08", pc_F, 32'hBFC0_0008);
    checkOutput("seq_pcd04", PC_D, 32'hBFC0_0004);

    applyStimulus(1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("stall_pc", pc_F, 32'hBFC0_0008);
      checkOutput("stall_instr", instr_D, memWord(32'hBFC0_0004));
      checkOutput("stall_pcd", PC_D, 32'hBFC0_0004);
      checkOutput("stall_valid", {31'b0, valid_D}, 32'h1);
    end
    applyStimulus(0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("unstall_pc", pc_F, 32'hBFC0_000C);
    checkOutput("unstall_pcd", PC_D, 32'hBFC0_0008);

    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("seq_pc", pc_F, 32'hBFC0_0010 + 32'(4 * i));
      checkOutput("seq_pcd", PC_D, 32'hBFC0_000C + 32'(4 * i));
      checkOutput("seq_pc4", PCPlus4_D, 32'hBFC0_0010 + 32'(4 * i));
    end

    applyStimulus(0, 0, 1, 1, 32'hBFC0_0102);
    tick();
    checkOutput("redir_pc", pc_F, 32'hBFC0_0100);
    checkOutput("redir_valid", {31'b0, valid_D}, 32'h0);
    checkOutput("redir_instr", instr_D, 32'h0000_0013);
    checkOutput("redir_pcd", PC_D, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("tgt_pcd", PC_D, 32'hBFC0_0100);
    checkOutput("tgt_instr", instr_D, memWord(32'hBFC0_0100));
    checkOutput("tgt_valid", {31'b0, valid_D}, 32'h1);
    checkOutput("tgt_pc", pc_F, 32'hBFC0_0104);

    applyStimulus(0, 1, 1, 0, 32'h0);
    tick();
    checkOutput("sdfd_valid", {31'b0, valid_D}, 32'h0);
    checkOutput("sdfd_instr", instr_D, 32'h0000_0013);
    checkOutput("sdfd_pc", pc_F, 32'hBFC0_0108);

    applyStimulus(1, 0, 0, 1, 32'h0000_0040);
    tick();
    checkOutput("sfred_pc", pc_F, 32'h0000_0040);
    checkOutput("sfred_pcd", PC_D, 32'hBFC0_0108);
    applyStimulus(0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("after40_pc", pc_F, 32'h0000_0044);

    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    checkOutput("sffd_pc", pc_F, 32'h0000_0044);
    checkOutput("sffd_valid", {31'b0, valid_D}, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("sffd_next_pcd", PC_D, 32'h0000_0044);

    applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFF);
    tick();
    checkOutput("wrap_tgt", pc_F, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("wrap_pc", pc_F, 32'h0000_0000);
    checkOutput("wrap_pcd", PC_D, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", PCPlus4_D, 32'h0000_0000);

    repeat (3) tick();
    checkOutput("pre_arst_pc", pc_F, 32'h0000_000C);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_pc", pc_F, 32'hBFC0_0000);
    checkOutput("arst_valid", {31'b0, valid_D}, 32'h0);
    checkOutput("arst_instr", instr_D, 32'h0000_0013);
    #1;
    rst = 1'b1;
    tick();
    checkOutput("refill_instr", instr_D, 32'hAC97_9BDF);
    checkOutput("refill_pc", pc_F, 32'hBFC0_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
